// File: rtl/variance_window_calc_pkg.sv
// ---------------------------------------------------------------------------
// Shared definitions for the variance corner cache and its consumer.
//
// pkg_varianceCache : word widths, cache address width, window/variance
//                     widths, corner address constants and the FSM state
//                     enum of variance_window_calc.
// structs           : read-port bundles of the variance corner cache.
//                     Read_in  = raddr/raddrSQ driven by the consumer.
//                     Read_out = q/qSQ returned by the cache one cycle later.
// ---------------------------------------------------------------------------
package pkg_varianceCache;

    localparam int WORD_SIZE    = 32;
    localparam int WORD_SIZE_SQ = 64;
    localparam int CACHE_ADDR_W = 2;
    localparam int AREA_BITS    = 16;
    localparam int VAR_WIDTH    = WORD_SIZE_SQ + AREA_BITS;

    // Corner order is identical for the plain and squared integral arrays
    localparam logic [CACHE_ADDR_W-1:0] CORNER_A = 2'd0;
    localparam logic [CACHE_ADDR_W-1:0] CORNER_B = 2'd1;
    localparam logic [CACHE_ADDR_W-1:0] CORNER_C = 2'd2;
    localparam logic [CACHE_ADDR_W-1:0] CORNER_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        MUL,
        RESULT,
        OUT
    } varcalc_state_t;

endpackage

package structs;

    typedef struct packed {
        logic [pkg_varianceCache::CACHE_ADDR_W-1:0] raddr;
        logic [pkg_varianceCache::CACHE_ADDR_W-1:0] raddrSQ;
    } struct_varianceCache_Read_in;

    typedef struct packed {
        logic [pkg_varianceCache::WORD_SIZE-1:0]    q;
        logic [pkg_varianceCache::WORD_SIZE_SQ-1:0] qSQ;
    } struct_varianceCache_Read_out;

endpackage

// File: rtl/variance_window_calc_core.sv
// ---------------------------------------------------------------------------
// variance_core: two-stage registered arithmetic for the window variance.
//   Stage 1 (i_mulEn) : p1 = area * sqsum, p2 = sum * sum
//   Stage 2 (i_resEn) : d = p1 - p2 (one bit wider), clamp negatives to 0,
//                       compare against the threshold.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   i_mulEn    : capture the two products
//   i_resEn    : capture the clamped variance and the pass flag
//   i_area     : window pixel count
//   i_sum      : window sum (wrapped)
//   i_sqsum    : window squared sum (wrapped)
//   i_thresh   : variance threshold
//   o_var      : clamped variance
//   o_pass     : o_var >= threshold
// ---------------------------------------------------------------------------
module variance_core
    import pkg_varianceCache::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_mulEn,
    input  logic                    i_resEn,
    input  logic [AREA_BITS-1:0]    i_area,
    input  logic [WORD_SIZE-1:0]    i_sum,
    input  logic [WORD_SIZE_SQ-1:0] i_sqsum,
    input  logic [VAR_WIDTH-1:0]    i_thresh,
    output logic [VAR_WIDTH-1:0]    o_var,
    output logic                    o_pass
);

    localparam int PROD_W = 2 * WORD_SIZE;

    logic [VAR_WIDTH-1:0] r_p1;
    logic [PROD_W-1:0]    r_p2;
    logic [VAR_WIDTH:0]   w_diff;
    logic [VAR_WIDTH-1:0] w_clamp;

    // Product stage: both multipliers are registered so the subtract and
    // compare get a full cycle on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1 <= '0;
            r_p2 <= '0;
        end else if (i_mulEn) begin
            r_p1 <= VAR_WIDTH'(i_area) * VAR_WIDTH'(i_sqsum);
            r_p2 <= PROD_W'(i_sum) * PROD_W'(i_sum);
        end
    end

    // The extra top bit of the difference is the sign; a wrapped sum can
    // make sum^2 exceed area*sqsum, and such windows report zero variance.
    always_comb begin
        w_diff  = {1'b0, r_p1} - (VAR_WIDTH + 1)'(r_p2);
        w_clamp = w_diff[VAR_WIDTH] ? '0 : w_diff[VAR_WIDTH-1:0];
    end

    // Result stage: held until the next window reaches this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_var  <= '0;
            o_pass <= 1'b0;
        end else if (i_resEn) begin
            o_var  <= w_clamp;
            o_pass <= (w_clamp >= i_thresh);
        end
    end

endmodule

// File: rtl/variance_window_calc.sv
// ---------------------------------------------------------------------------
// variance_window_calc: reads the four integral and four squared-integral
// corners of the current window from the variance corner cache, forms the
// window sum and squared sum, and reports AREA*sqsum - sum^2 (clamped at 0)
// together with a threshold pass flag over a valid/ready handshake.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start_valid  : request evaluation of the window held in the cache
//   start_ready  : high only while idle
//   win_area     : window pixel count, latched on start accept
//   thresh       : variance threshold, latched on start accept
//   vcr_in       : cache read addresses (raddr/raddrSQ)
//   vcr_out      : cache read data (q/qSQ), one cycle after the address
//   out_valid    : result available
//   out_ready    : consumer takes the result
//   var_out      : clamped variance
//   var_pass     : var_out >= thresh
// ---------------------------------------------------------------------------
module variance_window_calc
    import pkg_varianceCache::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_valid,
    output logic                                  start_ready,
    input  logic [AREA_BITS-1:0]                  win_area,
    input  logic [VAR_WIDTH-1:0]                  thresh,
    output structs::struct_varianceCache_Read_in  vcr_in,
    input  structs::struct_varianceCache_Read_out vcr_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [VAR_WIDTH-1:0]                  var_out,
    output logic                                  var_pass
);

    varcalc_state_t r_state;
    varcalc_state_t w_nextState;

    logic [CACHE_ADDR_W-1:0] r_cnt;
    logic [CACHE_ADDR_W-1:0] r_retAddr;
    logic                    r_retValid;
    logic [WORD_SIZE-1:0]    r_sum;
    logic [WORD_SIZE_SQ-1:0] r_sqsum;
    logic [AREA_BITS-1:0]    r_area;
    logic [VAR_WIDTH-1:0]    r_thresh;
    logic                    w_accept;

    assign w_accept    = start_valid && (r_state == IDLE);
    assign start_ready = (r_state == IDLE);
    assign out_valid   = (r_state == OUT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: READ lasts until the fourth address has gone out,
    // every other non-idle state is a single cycle except OUT, which waits
    // for the consumer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_nextState = READ;
            READ:    if (r_cnt == CORNER_D) w_nextState = DRAIN;
            DRAIN:   w_nextState = MUL;
            MUL:     w_nextState = RESULT;
            RESULT:  w_nextState = OUT;
            OUT:     if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Both arrays share one read counter; addresses are forced to zero
    // outside READ so the cache sees a quiet bus.
    always_comb begin
        vcr_in = '0;
        if (r_state == READ) begin
            vcr_in.raddr   = r_cnt;
            vcr_in.raddrSQ = r_cnt;
        end
    end

    // Read counter plus a one-cycle delayed copy of the issued address, so
    // returning cache data is tagged with the corner it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_retAddr  <= '0;
            r_retValid <= 1'b0;
        end else begin
            r_retValid <= (r_state == READ);
            r_retAddr  <= r_cnt;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == READ) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    // Window parameters are captured once so later input changes cannot
    // disturb a window in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_area   <= '0;
            r_thresh <= '0;
        end else if (w_accept) begin
            r_area   <= win_area;
            r_thresh <= thresh;
        end
    end

    // Corner accumulation A - B - C + D; both sums simply wrap, which is
    // exact for the integral-image difference as long as the true window
    // sum fits the word.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_sum   <= '0;
            r_sqsum <= '0;
        end else if (r_retValid) begin
            case (r_retAddr)
                CORNER_A, CORNER_D: begin
                    r_sum   <= r_sum + vcr_out.q;
                    r_sqsum <= r_sqsum + vcr_out.qSQ;
                end
                default: begin
                    r_sum   <= r_sum - vcr_out.q;
                    r_sqsum <= r_sqsum - vcr_out.qSQ;
                end
            endcase
        end
    end

    variance_core u_core (
        .clk      (clk),
        .rst      (rst),
        .i_mulEn  (r_state == MUL),
        .i_resEn  (r_state == RESULT),
        .i_area   (r_area),
        .i_sum    (r_sum),
        .i_sqsum  (r_sqsum),
        .i_thresh (r_thresh),
        .o_var    (var_out),
        .o_pass   (var_pass)
    );

endmodule

// File: tb/tb_variance_window_calc.sv
// ---------------------------------------------------------------------------
// tb_variance_window_calc: drives variance_window_calc with directed and
// random windows through a one-cycle-latency model of the corner cache and
// compares every result against a plain-arithmetic variance model.
// ---------------------------------------------------------------------------
module tb_variance_window_calc;
    import pkg_varianceCache::*;
    import structs::*;

    logic                         clk;
    logic                         rst;
    logic                         startValid;
    logic                         startReady;
    logic [AREA_BITS-1:0]         winArea;
    logic [VAR_WIDTH-1:0]         thresh;
    struct_varianceCache_Read_in  vcrIn;
    struct_varianceCache_Read_out vcrOut;
    logic                         outValid;
    logic                         outReady;
    logic [VAR_WIDTH-1:0]         varOut;
    logic                         varPass;

    logic [WORD_SIZE-1:0]    memQ  [4];
    logic [WORD_SIZE_SQ-1:0] memSQ [4];

    int vectors    = 0;
    int miscompares = 0;

    variance_window_calc dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (startValid),
        .start_ready (startReady),
        .win_area    (winArea),
        .thresh      (thresh),
        .vcr_in      (vcrIn),
        .vcr_out     (vcrOut),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .var_out     (varOut),
        .var_pass    (varPass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Corner cache: registered read, one cycle of latency
    always @(posedge clk) begin
        vcrOut.q   <= memQ[vcrIn.raddr];
        vcrOut.qSQ <= memSQ[vcrIn.raddrSQ];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Variance straight from the definition, using wide unsigned integers
    function automatic logic [VAR_WIDTH-1:0] refVariance(input logic [AREA_BITS-1:0] area);
        logic [WORD_SIZE-1:0]    s;
        logic [WORD_SIZE_SQ-1:0] sq;
        logic [129:0]            a, u, v, diff;
        s    = memQ[0] - memQ[1] - memQ[2] + memQ[3];
        sq   = memSQ[0] - memSQ[1] - memSQ[2] + memSQ[3];
        a    = 130'(area);
        u    = 130'(sq);
        v    = 130'(s);
        diff = a * u - v * v;
        if (diff[129]) return '0;
        return diff[VAR_WIDTH-1:0];
    endfunction

    task automatic setCorners(input logic [31:0] a, b, c, d, input logic [63:0] sa, sb, sc, sd);
        memQ[0] = a;  memQ[1] = b;  memQ[2] = c;  memQ[3] = d;
        memSQ[0] = sa; memSQ[1] = sb; memSQ[2] = sc; memSQ[3] = sd;
    endtask

    function automatic logic [VAR_WIDTH-1:0] randomWide();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[VAR_WIDTH-1:0];
    endfunction

    // One full window from an idle cycle: accept, address sequence, result,
    // optional backpressure, release. Returns in the cycle after the output
    // handshake with the block idle.
    task automatic applyStimulus(input logic [AREA_BITS-1:0] area, input logic [VAR_WIDTH-1:0] thr,
                                 input int holdCycles);
        logic [VAR_WIDTH-1:0] expVar;
        logic                 expPass;
        logic [1:0]           expAddr;
        expVar  = refVariance(area);
        expPass = (expVar >= thr);
        startValid = 1'b1;
        winArea    = area;
        thresh     = thr;
        outReady   = 1'b0;
        checkOutput("start_ready_T", 128'(startReady), 128'd1);
        tick;
        startValid = 1'b0;
        winArea    = 16'($urandom);
        thresh     = randomWide();
        for (int k = 1; k <= 7; k++) begin
            expAddr = (k <= 4) ? 2'(k - 1) : 2'd0;
            checkOutput("raddr", 128'(vcrIn.raddr), 128'(expAddr));
            checkOutput("raddrSQ", 128'(vcrIn.raddrSQ), 128'(expAddr));
            checkOutput("out_valid_early", 128'(outValid), 128'd0);
            checkOutput("start_ready_busy", 128'(startReady), 128'd0);
            tick;
        end
        for (int h = 0; h < holdCycles; h++) begin
            startValid = 1'b1;
            winArea    = 16'($urandom);
            checkOutput("hold_valid", 128'(outValid), 128'd1);
            checkOutput("hold_var", 128'(varOut), 128'(expVar));
            checkOutput("hold_pass", 128'(varPass), 128'(expPass));
            checkOutput("hold_start_ready", 128'(startReady), 128'd0);
            checkOutput("hold_raddr", 128'(vcrIn.raddr), 128'd0);
            tick;
        end
        startValid = 1'b0;
        outReady   = 1'b1;
        checkOutput("out_valid", 128'(outValid), 128'd1);
        checkOutput("var_out", 128'(varOut), 128'(expVar));
        checkOutput("var_pass", 128'(varPass), 128'(expPass));
        tick;
        outReady = 1'b0;
        checkOutput("idle_after_out", 128'(startReady), 128'd1);
        checkOutput("out_valid_after", 128'(outValid), 128'd0);
    endtask

    initial begin
        logic [VAR_WIDTH-1:0] expVar;
        logic [VAR_WIDTH-1:0] thr;
        logic [AREA_BITS-1:0] area;

        rst        = 1'b1;
        startValid = 1'b0;
        outReady   = 1'b0;
        winArea    = '0;
        thresh     = '0;
        setCorners(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick;
        rst = 1'b0;
        checkOutput("rst_start_ready", 128'(startReady), 128'd1);
        checkOutput("rst_out_valid", 128'(outValid), 128'd0);
        checkOutput("rst_var_out", 128'(varOut), 128'd0);
        checkOutput("rst_var_pass", 128'(varPass), 128'd0);
        checkOutput("rst_raddr", 128'(vcrIn.raddr), 128'd0);

        $display("[TB] basic pass / threshold edge");
        setCorners(10, 30, 40, 100, 100, 500, 600, 2000);
        applyStimulus(16, 14400, 0);
        applyStimulus(16, 14401, 0);

        $display("[TB] reset mid-operation");
        startValid = 1'b1;
        winArea    = 16;
        thresh     = 0;
        tick;
        startValid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("abort_start_ready", 128'(startReady), 128'd1);
        checkOutput("abort_out_valid", 128'(outValid), 128'd0);
        checkOutput("abort_var_out", 128'(varOut), 128'd0);
        checkOutput("abort_raddr", 128'(vcrIn.raddr), 128'd0);
        for (int i = 0; i < 12; i++) begin
            checkOutput("abort_no_result", 128'(outValid), 128'd0);
            tick;
        end
        applyStimulus(16, 14400, 0);

        $display("[TB] wrap-around");
        setCorners(32'hFFFF_FFF0, 32'hFFFF_FFF8, 0, 32'h10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0);
        setCorners(32'hFFFF_FFF0, 32'hFFFF_FFF8, 0, 32'h10, 0, 0, 0, 100);
        applyStimulus(1, 36, 0);

        $display("[TB] negative clamp");
        setCorners(0, 0, 0, 100, 0, 0, 0, 10);
        applyStimulus(16, 0, 0);
        applyStimulus(16, 1, 0);

        $display("[TB] backpressure and back-to-back start");
        setCorners(10, 30, 40, 100, 100, 500, 600, 2000);
        applyStimulus(16, 100, 5);
        setCorners(5, 7, 9, 50, 25, 49, 81, 4000);
        applyStimulus(20, 1000, 0);

        $display("[TB] random windows");
        for (int n = 0; n < 24; n++) begin
            setCorners($urandom, $urandom, $urandom, $urandom,
                       {$urandom, $urandom}, {$urandom, $urandom},
                       {$urandom, $urandom}, {$urandom, $urandom});
            if (n % 4 == 0) begin
                memQ[1] = memQ[0];
                memQ[2] = memQ[3];
            end
            area   = 16'($urandom);
            expVar = refVariance(area);
            case ($urandom_range(0, 2))
                0:       thr = expVar;
                1:       thr = expVar + 1'b1;
                default: thr = randomWide();
            endcase
            applyStimulus(area, thr, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
